// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants: default pixel width, feature-map size, pool size and row-parity states.
package cnn_pkg;
    localparam int MP_WIDTH_DEF = 16;
    localparam int IMG_DIM_DEF  = 416;
    localparam int POOL_K       = 2;

    localparam logic [0:0] ROW_EVEN = 1'b0;
    localparam logic [0:0] ROW_ODD  = 1'b1;
endpackage

// File: rtl/cnn_mp_window_buffer_if.sv
// Pixel-in / 2x2-window-out bundle for the max-pool window buffer; win_cnt exists only with MP_WIN_CNT_EN.
// No ready signals anywhere: the stream is valid-only.
interface cnn_mp_window_buffer_if
    import cnn_pkg::*;
#(
    parameter int MP_Width = MP_WIDTH_DEF
);
    logic                       in_valid;
    logic signed [MP_Width-1:0] in_data;
    logic                       win_valid;
    logic signed [MP_Width-1:0] win_data_0;
    logic signed [MP_Width-1:0] win_data_1;
    logic signed [MP_Width-1:0] win_data_2;
    logic signed [MP_Width-1:0] win_data_3;
    logic                       frame_done;
`ifdef MP_WIN_CNT_EN
    logic [15:0]                win_cnt;
`endif

    modport slave (
        input  in_valid, in_data,
        output win_valid, win_data_0, win_data_1, win_data_2, win_data_3, frame_done
`ifdef MP_WIN_CNT_EN
        , output win_cnt
`endif
    );

    modport master (
        output in_valid, in_data,
        input  win_valid, win_data_0, win_data_1, win_data_2, win_data_3, frame_done
`ifdef MP_WIN_CNT_EN
        , input win_cnt
`endif
    );
endinterface

// File: rtl/cnn_line_buffer.sv
// One-row line buffer: synchronous write, synchronous paired read of entries addr and addr+1, no storage reset.
// Read data holds until the next read enable.
module cnn_line_buffer #(
    parameter int DEPTH = 416,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_0_o,
    output logic [WIDTH-1:0] rd_data_1_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_0_q;
    logic [WIDTH-1:0] rd_data_1_q;
    logic [AW-1:0]    rd_addr_p1;

    assign rd_addr_p1 = rd_addr_i + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_0_q <= mem[rd_addr_i];
            rd_data_1_q <= mem[rd_addr_p1];
        end
    end

    assign rd_data_0_o = rd_data_0_q;
    assign rd_data_1_o = rd_data_1_q;
endmodule

// File: rtl/cnn_mp_window_buffer.sv
// Builds stride-2 2x2 windows from a raster pixel stream; window registered 1 cycle after its bottom-right pixel.
// Valid-only, no backpressure. Optional MP_WIN_CNT_EN adds a per-frame window counter.
module cnn_mp_window_buffer
    import cnn_pkg::*;
#(
    parameter int MP_Width = MP_WIDTH_DEF,
    parameter int IMG_W    = IMG_DIM_DEF,
    parameter int IMG_H    = IMG_DIM_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cnn_mp_window_buffer_if.slave  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [0:0]          state;
    logic                col_last, row_last;
    logic                lb_wr, lb_rd, fire;
    logic [MP_Width-1:0] top_0, top_1;
    logic [MP_Width-1:0] hold_q;
    logic                win_valid_q, frame_done_q;
    logic [MP_Width-1:0] win_0_q, win_1_q, win_2_q, win_3_q;

    // Row parity is the whole state: even rows fill the buffer, odd rows emit windows.
    assign state    = row_q[0];
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign lb_wr    = bus.in_valid && (state == ROW_EVEN);
    assign lb_rd    = bus.in_valid && (state == ROW_ODD) && !col_q[0];
    assign fire     = bus.in_valid && (state == ROW_ODD) && col_q[0];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (bus.in_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    cnn_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (MP_Width),
        .AW    (CW)
    ) u_line_buffer (
        .clk         (clk),
        .wr_en_i     (lb_wr),
        .wr_addr_i   (col_q),
        .wr_data_i   (bus.in_data),
        .rd_en_i     (lb_rd),
        .rd_addr_i   (col_q),
        .rd_data_0_o (top_0),
        .rd_data_1_o (top_1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_0_q      <= '0;
            win_1_q      <= '0;
            win_2_q      <= '0;
            win_3_q      <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= fire;
            frame_done_q <= fire && row_last && col_last;
            if (lb_rd) begin
                hold_q <= bus.in_data;
            end
            if (fire) begin
                win_0_q <= top_0;
                win_1_q <= top_1;
                win_2_q <= hold_q;
                win_3_q <= bus.in_data;
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.win_data_0 = win_0_q;
    assign bus.win_data_1 = win_1_q;
    assign bus.win_data_2 = win_2_q;
    assign bus.win_data_3 = win_3_q;

`ifdef MP_WIN_CNT_EN
    logic [15:0] win_cnt_q, win_cnt_d;

    // Count restarts the cycle after frame_done so the final count stays visible with the last window.
    assign win_cnt_d = (frame_done_q ? 16'd0 : win_cnt_q) + {15'd0, fire};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
        end
    end

    assign bus.win_cnt = win_cnt_q;
`endif
endmodule

// File: doc/cnn_mp_window_buffer.md
Name: cnn_mp_window_buffer

Overview:
- Upstream neighbour of the 2x2 max-pooling stage.
- Accepts a raster-order stream of activation pixels (one per cycle max, row-major, one channel plane per frame) and buffers one full row.
- Emits one registered 2x2 window (four pixels + valid strobe) per stride-2 pooling position, wired directly to the pooling stage's four data inputs and its valid input.
- The pooling stage has no backpressure, so this block has none either: valid-only streaming.

Parameters:
- MP_Width, 16, signed pixel width; must match the pooling stage.
- IMG_W, 416, pixels per row; must be even and >= 2.
- IMG_H, 416, rows per frame; must be even and >= 2.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_data carries the next raster pixel this cycle.
- in_data  input  MP_Width  signed pixel.
- win_valid  output  1  window outputs valid this cycle; drives pooling valid.
- win_data_0  output  MP_Width  top-left (row r-1, col c-1).
- win_data_1  output  MP_Width  top-right (row r-1, col c).
- win_data_2  output  MP_Width  bottom-left (row r, col c-1).
- win_data_3  output  MP_Width  bottom-right (row r, col c).
- frame_done  output  1  one-cycle pulse alongside the last window of a frame.

Behaviour:
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1), both advance only on in_valid. col wraps to 0 and row increments at col==IMG_W-1. Both wrap to 0 after the last pixel of the frame, so back-to-back frames need no idle gap.
- Line buffer: IMG_W x MP_Width single-port memory, written at address col on every accepted pixel of an even row. Odd rows read it; no write.
- State machine, 2 states, derived from row[0]:
  - ROW_EVEN: store pixels; win_valid=0.
  - ROW_ODD:
    - even col: capture pixel into hold register and read line buffer entries col and col+1 into top registers (or read both addresses as a pair).
    - odd col: register the window using top-left/top-right from the line buffer, bottom-left from the hold register, bottom-right = in_data; win_valid=1 next cycle.
- Latency: win_valid and win_data_* appear exactly 1 cycle after the in_valid cycle that delivers the bottom-right pixel.
- Output registers:
  - win_data_* hold their value when win_valid=0.
  - win_valid is high for exactly one cycle per window.
- Window count: (IMG_W/2)*(IMG_H/2) per frame.
- frame_done=1 in the same cycle as the window for row IMG_H-1, col IMG_W-1.
- in_valid gaps (bubbles) anywhere: state, counters and hold register freeze; no spurious window.
- Arithmetic: no arithmetic on data; pixels pass bit-exact, sign preserved.
- Reset values:
  - win_valid=0, frame_done=0, win_data_0..3=0.
  - col=0, row=0, hold register=0.
  - Line buffer contents are not cleared; they are don't-care because they are rewritten before reuse.
- Reset mid-frame: all of the above return to reset values on the next clk edge. The next accepted pixel is treated as (0,0). Any partial window is discarded.

Optional Feature:
- Macro: MP_WIN_CNT_EN.
- Defined:
  - Adds output port win_cnt (16 bits), the number of windows emitted in the current frame.
  - Increments with each win_valid and clears to 0 on the cycle after frame_done and on reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package cnn_pkg:
  - pixel width default (MP_Width)
  - default feature-map dimensions (416)
  - pool window size constant (2)
  - row-parity state encoding
- One natural sub-module: cnn_line_buffer (parameterised depth/width, synchronous write, synchronous read, no reset on storage), reusable by later convolution window stages.

Test Plan (IMG_W=4, IMG_H=4 unless noted):
1. Continuous frame, pixels 0..15 raster, in_valid=1 every cycle:
   - exactly 4 windows: (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15), in that order.
   - each window appears 1 cycle after pixels 5, 7, 13, 15 respectively.
   - frame_done only with the last window.
2. Same frame with in_valid toggling 1,0,1,0: identical windows and order, no extra win_valid, win_data held during gaps.
3. Signed data: row 0 = -1,-32768,32767,0 and row 1 = -2,5,-7,-3:
   - windows (-1,-32768,-2,5) and (32767,0,-7,-3), bit-exact.
   - pooling stage downstream outputs 5 then 32767.
4. Two back-to-back frames with no gap (pixels 0..31): 8 windows; second frame windows (16,17,20,21)...(26,27,30,31); two frame_done pulses.
5. rst_n=0 for one cycle after pixel 9 of a frame, then a fresh 16-pixel frame 100..115:
   - outputs zero during reset.
   - first window is (100,101,104,105); no window mixes pre-reset data.
6. With MP_WIN_CNT_EN defined, run scenario 1: win_cnt goes 1,2,3,4, then returns to 0 the cycle after frame_done.
